logic_unit_pipe: RTL

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 7 +
 rtl/logic_op_core.sv | 27 ++
 rtl/logic_unit_pipe.sv | 53 +++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared op-code enumeration and op-select width for the logic unit pipe
package logic_unit_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_NOT, OP_RSVD
  } op_e;
endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: combinational bitwise op unit; ports a, b, op -> result, err (err flags the reserved op, which yields 0)
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op_e'(op))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = ~a;
      default: err    = 1'b1;
    endcase
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: one-stage valid/ready logic unit with accumulator; in: clk rst_n in_valid op acc a b out_ready, out: in_ready out_valid z zero parity op_err
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic             parity,
  output logic             op_err
);
  logic [WIDTH-1:0] acc_q, op_a, result;
  logic             err, accept;
  assign op_a     = (ACC_EN && acc) ? acc_q : a;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // flags derive from the held result so they stay coherent with z under backpressure
  assign zero     = ~|z;
  assign parity   = ^z;
  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a      (op_a),
    .b      (b),
    .op     (op),
    .result (result),
    .err    (err)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      z         <= '0;
      op_err    <= 1'b0;
      acc_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      z         <= result;
      op_err    <= err;
      acc_q     <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
